ara_axi_mem_responder: RTL
==========================

Name: ara_axi_mem_responder

Overview:
- AXI4 subordinate that answers the AXI manager port of Ara's vector load/store unit; it is the responder end of the axi_req_o/axi_resp_i interface.
- Backs the port with an internal word-addressed register memory.
- Serves one read burst and one write burst concurrently, with independent FSMs.
- Used in standalone lane/VLSU system benches and small-memory configurations.

Parameters:
- AxiDataWidth, 64, data bus width in bits; power of two, at least 64.
- AxiAddrWidth, 64, address width in bits.
- NumWords, 1024, memory depth in AxiDataWidth-bit words; power of two.
- BaseAddr, 0, byte address of word 0.
- axi_req_t, logic, AXI request struct type: aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready.
- axi_resp_t, logic, AXI response struct type: aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- axi_req_i  in  $bits(axi_req_t)  request from the Ara manager.
- axi_resp_o  out  $bits(axi_resp_t)  response to the Ara manager.
- busy_o  out  1  a read or write burst is in progress.

Behaviour:
- Reset:
  - All valid/ready outputs are 0; busy_o is 0.
  - Both FSMs go to IDLE.
  - Memory contents are cleared to 0.
  - Reset asserted mid-burst aborts the burst immediately; no B or further R beats are produced.
- Address math:
  - off = addr - BaseAddr; word index = off >> log2(AxiDataWidth/8).
  - In range when BaseAddr <= addr < BaseAddr + NumWords*AxiDataWidth/8, evaluated per beat.
  - Burst FIXED: the address is constant across beats.
  - Burst INCR: next = (addr aligned down to 2^size) + 2^size.
  - Burst WRAP: treated as INCR.
  - len is 0..255, so beats = len + 1.
- Read FSM, states IDLE -> RBURST -> IDLE:
  - ar_ready = 1 only in IDLE.
  - On the ar_valid && ar_ready handshake, latch id, addr, len, size, burst, then go to RBURST.
  - r_valid rises the cycle after acceptance: one-cycle latency.
  - Each beat:
    - r.data = full word at the current index;
    - r.resp = OKAY if in range, DECERR otherwise, with data 0;
    - r.id = latched id;
    - r.last = 1 when the beat counter equals len.
  - R outputs are held stable while r_valid && !r_ready.
  - On handshake: advance the address and counter; go to IDLE after the last beat.
  - Back-to-back: a new AR is accepted the cycle after the last R handshake, never on the same cycle.
- Write FSM, states IDLE -> WDATA -> WRESP -> IDLE:
  - aw_ready = 1 only in IDLE; latch the AW fields on handshake.
  - w_ready = 1 only in WDATA.
  - Per accepted beat:
    - if in range, bytes with w.strb set are written at the end of that cycle;
    - if out of range, the beat is dropped and a sticky decerr flag is set.
  - Leave WDATA on the beat whose beat counter equals len; w.last is ignored for sequencing.
  - WRESP: b_valid = 1, b.id = latched id, b.resp = DECERR if the sticky flag is set, else OKAY. Hold until b_ready; then clear the flag and go to IDLE.
  - W beats presented before AW acceptance are not accepted (w_ready = 0).
- Same-word collision: a write beat and a read beat to the same word in the same cycle return the OLD data on R; the write lands for subsequent reads.
- busy_o = (read FSM != IDLE) || (write FSM != IDLE).
- All unused response fields (user, etc.) are driven 0.

Test Plan:
- Single-beat write then read: AW addr=BaseAddr+0x10, len=0, size=3, W data=0x1122334455667788, strb=0xFF. Required: B OKAY one cycle after the W handshake; a following AR at the same address returns that data with r.last=1.
- INCR 4-beat write with strb=0x0F on beat 2, then 4-beat INCR read. Required: beat 2 upper 4 bytes remain 0; other beats are returned intact with r.last only on beat 3.
- FIXED 3-beat write to one word with data 1, 2, 3. Required: a read returns 3.
- R backpressure: r_ready held low 5 cycles on beat 1 of an 8-beat read. Required: r.data, r.id and r.last are stable throughout, with no lost or duplicated beat.
- Out-of-range: 2-beat write straddling the top of memory. Required: the in-range beat is written and B=DECERR. A read at BaseAddr+NumWords*8 returns DECERR with data 0.
- Concurrent read and write to the same word in the same cycle. Required: R returns the old value and the next read returns the new one. Assert rst_i mid-burst: all valids drop to 0 asynchronously and busy_o=0.

Source files
------------

// File: rtl/ara_axi_mem_responder.sv
// AXI4 subordinate backing Ara's VLSU manager port with a word-addressed register memory.
// One read burst and one write burst are served concurrently by independent FSMs.
package ara_axi_mem_responder_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic        user;
  } ara_aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } ara_w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic       user;
  } ara_b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic        user;
  } ara_ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } ara_r_chan_t;

  typedef struct packed {
    ara_aw_chan_t aw;
    logic         aw_valid;
    ara_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    ara_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } ara_axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    ara_b_chan_t b;
    logic        b_valid;
    logic        ar_ready;
    ara_r_chan_t r;
    logic        r_valid;
  } ara_axi_resp_t;
endpackage

module ara_axi_mem_responder
  import ara_axi_mem_responder_pkg::*;
#(
  parameter int unsigned             AxiDataWidth = 64,
  parameter int unsigned             AxiAddrWidth = 64,
  parameter int unsigned             NumWords     = 1024,
  parameter logic [AxiAddrWidth-1:0] BaseAddr     = {AxiAddrWidth{1'b0}},
  parameter type                     axi_req_t    = ara_axi_req_t,
  parameter type                     axi_resp_t   = ara_axi_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  axi_req_t  axi_req_i,
  output axi_resp_t axi_resp_o,
  output logic      busy_o
);

  localparam int unsigned StrbW = AxiDataWidth / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(NumWords);
  localparam int unsigned IdW   = $bits(axi_req_i.ar.id);
  localparam logic [AxiAddrWidth-1:0] MemBytes = AxiAddrWidth'(NumWords) << OffW;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespDecerr = 2'b11;
  localparam logic [1:0] BurstFixed = 2'b00;

  typedef enum logic [0:0] {R_IDLE, R_BURST} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

  function automatic logic in_range(input logic [AxiAddrWidth-1:0] addr);
    logic [AxiAddrWidth-1:0] off;
    off = addr - BaseAddr;
    return (addr >= BaseAddr) && (off < MemBytes);
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [AxiAddrWidth-1:0] addr);
    return IdxW'((addr - BaseAddr) >> OffW);
  endfunction

  // WRAP bursts deliberately fall through to INCR stepping
  function automatic logic [AxiAddrWidth-1:0] next_addr(input logic [AxiAddrWidth-1:0] addr,
                                                         input logic [2:0] size,
                                                         input logic [1:0] burst);
    logic [AxiAddrWidth-1:0] step;
    step = {{(AxiAddrWidth-1){1'b0}}, 1'b1} << size;
    if (burst == BurstFixed) begin
      return addr;
    end else begin
      return (addr & ~(step - {{(AxiAddrWidth-1){1'b0}}, 1'b1})) + step;
    end
  endfunction

  logic [AxiDataWidth-1:0] r_mem [NumWords];
  logic                    r_live;

  rstate_e                 r_rstate, w_rstate_nxt;
  logic [IdW-1:0]          r_rid;
  logic [AxiAddrWidth-1:0] r_raddr;
  logic [7:0]              r_rlen, r_rcnt;
  logic [2:0]              r_rsize;
  logic [1:0]              r_rburst;
  logic [AxiDataWidth-1:0] r_rdata;
  logic [1:0]              r_rresp;

  wstate_e                 r_wstate, w_wstate_nxt;
  logic [IdW-1:0]          r_wid;
  logic [AxiAddrWidth-1:0] r_waddr;
  logic [7:0]              r_wlen, r_wcnt;
  logic [2:0]              r_wsize;
  logic [1:0]              r_wburst;
  logic                    r_wdecerr;

  logic                    w_ar_ready, w_r_valid, w_aw_ready, w_w_ready, w_b_valid;
  logic                    w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_we;
  logic                    w_rlast, w_wlast;
  logic [AxiAddrWidth-1:0] w_rnext_addr, w_rload_addr, w_wnext_addr;
  logic [AxiDataWidth-1:0] w_rload_data;
  logic [1:0]              w_rload_resp;
  logic                    w_unused_req;

  assign w_unused_req = ^axi_req_i;

  assign w_ar_hs      = w_ar_ready && axi_req_i.ar_valid;
  assign w_r_hs       = w_r_valid && axi_req_i.r_ready;
  assign w_aw_hs      = w_aw_ready && axi_req_i.aw_valid;
  assign w_w_hs       = w_w_ready && axi_req_i.w_valid;
  assign w_b_hs       = w_b_valid && axi_req_i.b_ready;
  assign w_rlast      = (r_rcnt == r_rlen);
  assign w_wlast      = (r_wcnt == r_wlen);
  assign w_rnext_addr = next_addr(r_raddr, r_rsize, r_rburst);
  assign w_wnext_addr = next_addr(r_waddr, r_wsize, r_wburst);
  assign w_we         = w_w_hs && in_range(r_waddr);
  assign busy_o       = (r_rstate != R_IDLE) || (r_wstate != W_IDLE);

  // R data is captured into a register so it stays stable under backpressure
  always_comb begin
    w_rload_addr = (r_rstate == R_IDLE) ? axi_req_i.ar.addr : w_rnext_addr;
    if (in_range(w_rload_addr)) begin
      w_rload_data = r_mem[word_idx(w_rload_addr)];
      w_rload_resp = RespOkay;
    end else begin
      w_rload_data = {AxiDataWidth{1'b0}};
      w_rload_resp = RespDecerr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_live <= 1'b0;
      for (int i = 0; i < NumWords; i++) begin
        r_mem[i] <= {AxiDataWidth{1'b0}};
      end
    end else begin
      r_live <= 1'b1;
      if (w_we) begin
        for (int b = 0; b < StrbW; b++) begin
          if (axi_req_i.w.strb[b]) begin
            r_mem[word_idx(r_waddr)][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rstate <= R_IDLE;
      r_rid    <= {IdW{1'b0}};
      r_raddr  <= {AxiAddrWidth{1'b0}};
      r_rlen   <= 8'd0;
      r_rcnt   <= 8'd0;
      r_rsize  <= 3'd0;
      r_rburst <= 2'd0;
      r_rdata  <= {AxiDataWidth{1'b0}};
      r_rresp  <= 2'd0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_rid    <= axi_req_i.ar.id;
        r_raddr  <= axi_req_i.ar.addr;
        r_rlen   <= axi_req_i.ar.len;
        r_rcnt   <= 8'd0;
        r_rsize  <= axi_req_i.ar.size;
        r_rburst <= axi_req_i.ar.burst;
        r_rdata  <= w_rload_data;
        r_rresp  <= w_rload_resp;
      end else if (w_r_hs && !w_rlast) begin
        r_raddr  <= w_rnext_addr;
        r_rcnt   <= r_rcnt + 8'd1;
        r_rdata  <= w_rload_data;
        r_rresp  <= w_rload_resp;
      end
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_ar_ready   = 1'b0;
    w_r_valid    = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_ar_ready = r_live;
        if (r_live && axi_req_i.ar_valid) begin
          w_rstate_nxt = R_BURST;
        end else begin
          w_rstate_nxt = R_IDLE;
        end
      end
      R_BURST: begin
        w_r_valid = 1'b1;
        if (axi_req_i.r_ready && w_rlast) begin
          w_rstate_nxt = R_IDLE;
        end else begin
          w_rstate_nxt = R_BURST;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wstate  <= W_IDLE;
      r_wid     <= {IdW{1'b0}};
      r_waddr   <= {AxiAddrWidth{1'b0}};
      r_wlen    <= 8'd0;
      r_wcnt    <= 8'd0;
      r_wsize   <= 3'd0;
      r_wburst  <= 2'd0;
      r_wdecerr <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) begin
        r_wid     <= axi_req_i.aw.id;
        r_waddr   <= axi_req_i.aw.addr;
        r_wlen    <= axi_req_i.aw.len;
        r_wcnt    <= 8'd0;
        r_wsize   <= axi_req_i.aw.size;
        r_wburst  <= axi_req_i.aw.burst;
        r_wdecerr <= 1'b0;
      end else if (w_w_hs) begin
        if (!in_range(r_waddr)) begin
          r_wdecerr <= 1'b1;
        end
        if (!w_wlast) begin
          r_waddr <= w_wnext_addr;
          r_wcnt  <= r_wcnt + 8'd1;
        end
      end else if (w_b_hs) begin
        r_wdecerr <= 1'b0;
      end
    end
  end

  // W sequencing counts beats against len; w.last is not consulted
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_aw_ready   = 1'b0;
    w_w_ready    = 1'b0;
    w_b_valid    = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_aw_ready = r_live;
        if (r_live && axi_req_i.aw_valid) begin
          w_wstate_nxt = W_DATA;
        end else begin
          w_wstate_nxt = W_IDLE;
        end
      end
      W_DATA: begin
        w_w_ready = 1'b1;
        if (axi_req_i.w_valid && w_wlast) begin
          w_wstate_nxt = W_RESP;
        end else begin
          w_wstate_nxt = W_DATA;
        end
      end
      W_RESP: begin
        w_b_valid = 1'b1;
        if (axi_req_i.b_ready) begin
          w_wstate_nxt = W_IDLE;
        end else begin
          w_wstate_nxt = W_RESP;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = w_aw_ready;
    axi_resp_o.w_ready  = w_w_ready;
    axi_resp_o.b_valid  = w_b_valid;
    axi_resp_o.b.id     = r_wid;
    axi_resp_o.b.resp   = r_wdecerr ? RespDecerr : RespOkay;
    axi_resp_o.ar_ready = w_ar_ready;
    axi_resp_o.r_valid  = w_r_valid;
    axi_resp_o.r.id     = r_rid;
    axi_resp_o.r.data   = r_rdata;
    axi_resp_o.r.resp   = r_rresp;
    axi_resp_o.r.last   = w_rlast;
  end

endmodule
